// File: rtl/uart_pkg.sv
// Shared receiver types and the active-low hex seven-segment lookup.
// UART_PARITY_EN adds the PARITY state for the even-parity build.
package uart_pkg;

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } rx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } rx_state_t;
`endif

   // Segment bits are {g,f,e,d,c,b,a}; a 0 lights the segment.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial frame receiver: synchronizer, mid-bit sampling FSM, one-cycle done/bad pulses.
// UART_PARITY_EN enables the even-parity bit check between DATA and STOP.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] data,
   output logic                 frame_done,
   output logic                 frame_bad,
   output rx_state_t            state
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

   logic [1:0]           sync;
   logic                 rx_s;
   rx_state_t            state_next;
   logic [CW-1:0]        cnt, cnt_next;
   logic [BW-1:0]        idx, idx_next;
   logic [DATA_BITS-1:0] shreg, shreg_next;
   logic                 done_next, bad_next;
   logic                 par_ok;
`ifdef UART_PARITY_EN
   logic                 par_ok_next;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], rx_serial};
   end

   assign rx_s = sync[1];
   assign data = shreg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         frame_done <= 1'b0;
         frame_bad  <= 1'b0;
`ifdef UART_PARITY_EN
         par_ok     <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         idx        <= idx_next;
         shreg      <= shreg_next;
         frame_done <= done_next;
         frame_bad  <= bad_next;
`ifdef UART_PARITY_EN
         par_ok     <= par_ok_next;
`endif
      end
   end

`ifndef UART_PARITY_EN
   assign par_ok = 1'b1;
`endif

   // The bit counter free-runs inside each state and is cleared on every sample point.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      idx_next   = idx;
      shreg_next = shreg;
      done_next  = 1'b0;
      bad_next   = 1'b0;
`ifdef UART_PARITY_EN
      par_ok_next = par_ok;
`endif
      case (state)
         IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next   = '0;
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_next   = '0;
               shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
               idx_next   = idx + 1'b1;
               if (idx == IDX_LAST) begin
                  idx_next = '0;
`ifdef UART_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_next    = '0;
               par_ok_next = (rx_s == ^shreg);
               state_next  = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rx_s && par_ok) done_next = 1'b1;
               else                bad_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/uart_rx_fifo_display.sv
// UART receiver with show-ahead FIFO, sticky error flags and a hex seven-segment display.
// Define UART_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_fifo_display
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int NUM_DIGITS   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_serial,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [DATA_BITS-1:0]          rx_byte,
   output logic                          rx_valid,
   output logic                          rx_dv_n,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [7*NUM_DIGITS-1:0]       ssg
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int DW   = 4 * NUM_DIGITS;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

   logic [DATA_BITS-1:0] core_data;
   logic                 core_done;
   logic                 core_bad;
   rx_state_t            core_state;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CNTW-1:0]      count;
   logic                 full, push, pop, drop;

   logic [DW-1:0]            disp;
   logic [DW+DATA_BITS-1:0]  disp_ext;

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_BITS    (DATA_BITS)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_serial  (rx_serial),
      .data       (core_data),
      .frame_done (core_done),
      .frame_bad  (core_bad),
      .state      (core_state)
   );

   assign full = (count == FULL_CNT);
   assign pop  = rd_en && (count != '0);
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push = core_done && (!full || pop);
   assign drop = core_done && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= core_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rx_valid   = (count != '0);
   assign rx_byte    = rx_valid ? mem[rd_ptr] : '0;
   assign fifo_count = count;
   assign rx_dv_n    = ~core_done;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (core_bad)     frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (drop)         overflow  <= 1'b1;
         else if (err_clr) overflow  <= 1'b0;
      end
   end

   assign disp_ext = {{DW{1'b0}}, core_data};

   always_ff @(posedge clk) begin
      if (!rst_n)         disp <= '0;
      else if (core_done) disp <= disp_ext[DW-1:0];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!rst_n) ssg[7*i +: 7] <= hex7(4'h0);
         else        ssg[7*i +: 7] <= hex7(disp[4*i +: 4]);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_display.sv
// Scoreboarded bench for uart_rx_fifo_display at 16 clocks per bit, 8 data bits, 16-deep FIFO.
// Honours UART_PARITY_EN when building frames and adds a bad-parity case.
module tb_uart_rx_fifo_display;
   import uart_pkg::*;

   localparam int CPB = 16;
   localparam int DB  = 8;
   localparam int FD  = 16;
   localparam int ND  = 2;

   // Active-high {g..a} glyphs; the display drives their complement.
   localparam logic [6:0] SEG_ON [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_serial = 1'b1;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DB-1:0] rx_byte;
   logic          rx_valid;
   logic          rx_dv_n;
   logic [4:0]    fifo_count;
   logic          frame_err;
   logic          overflow;
   logic [13:0]   ssg;

   int vectors = 0;
   int miscompares = 0;
   logic [DB-1:0] exp_q[$];
   logic [DB-1:0] frame_q[$];

   uart_rx_fifo_display #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .FIFO_DEPTH   (FD),
      .NUM_DIGITS   (ND)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_serial  (rx_serial),
      .rd_en      (rd_en),
      .err_clr    (err_clr),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .rx_dv_n    (rx_dv_n),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .ssg        (ssg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [13:0] exp_ssg(input logic [7:0] b);
      logic [3:0] hi, lo;
      hi = b[7:4];
      lo = b[3:0];
      return {~SEG_ON[hi], ~SEG_ON[lo]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_raw(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx_serial = bits[i];
         wait_cycles(CPB);
      end
      rx_serial = 1'b1;
      wait_cycles(2 * CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_PARITY_EN
      send_raw({5'b0, stop_b, ^d, d, 1'b0}, 11);
`else
      send_raw({6'b0, stop_b, d, 1'b0}, 10);
`endif
   endtask

   task automatic pop_expect(input logic [7:0] d);
      exp_q.push_back(d);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
   endtask

   // ---------------- scoreboard monitors ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rd_en && rx_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL pop_unexpected: got 0x%0h, expected no pop", rx_byte);
            end else begin
               check("pop_data", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (rst_n && !rx_dv_n) begin
            if (frame_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL dv_unexpected: got rx_dv_n=0, expected 1");
            end else begin
               d = frame_q.pop_front();
               @(negedge clk);
               check("dv_width", 32'(rx_dv_n), 32'd1);
               @(negedge clk);
               check("ssg_after_frame", 32'(ssg), 32'(exp_ssg(d)));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n = 1'b0;
      wait_cycles(4);
      check("rst_rx_byte",    32'(rx_byte),    32'd0);
      check("rst_rx_valid",   32'(rx_valid),   32'd0);
      check("rst_rx_dv_n",    32'(rx_dv_n),    32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_frame_err",  32'(frame_err),  32'd0);
      check("rst_overflow",   32'(overflow),   32'd0);
      check("rst_ssg",        32'(ssg),        32'(exp_ssg(8'h00)));
      rst_n = 1'b1;
      wait_cycles(4);

      // single frame 0xA5
      frame_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      check("a5_rx_byte",    32'(rx_byte),    32'hA5);
      check("a5_rx_valid",   32'(rx_valid),   32'd1);
      check("a5_fifo_count", 32'(fifo_count), 32'd1);
      check("a5_ssg",        32'(ssg),        32'h0412);
      pop_expect(8'hA5);
      check("a5_drained", 32'(fifo_count), 32'd0);

      // read while empty is ignored
      rd_en = 1'b1;
      wait_cycles(3);
      rd_en = 1'b0;
      tick();
      check("empty_rd_count", 32'(fifo_count), 32'd0);
      check("empty_rd_byte",  32'(rx_byte),    32'd0);
      check("empty_rd_valid", 32'(rx_valid),   32'd0);

      // bad stop bit on 0x3C
      send_frame(8'h3C, 1'b0);
      check("badstop_frame_err", 32'(frame_err),  32'd1);
      check("badstop_count",     32'(fifo_count), 32'd0);
      check("badstop_ssg",       32'(ssg),        32'(exp_ssg(8'hA5)));
      pulse_err_clr();
      check("badstop_cleared",   32'(frame_err),  32'd0);

      // 4-cycle glitch in IDLE
      rx_serial = 1'b0;
      wait_cycles(4);
      rx_serial = 1'b1;
      wait_cycles(3 * CPB);
      check("glitch_state",     32'(dut.u_core.state), 32'(IDLE));
      check("glitch_frame_err", 32'(frame_err),        32'd0);
      check("glitch_count",     32'(fifo_count),       32'd0);

      // 17 frames with no reads: 16 stored, last dropped
      for (int i = 0; i <= 16; i++) begin
         frame_q.push_back(8'(i));
         send_frame(8'(i), 1'b1);
      end
      check("fill_count",    32'(fifo_count), 32'd16);
      check("fill_overflow", 32'(overflow),   32'd1);
      check("fill_head",     32'(rx_byte),    32'h00);
      check("fill_ssg",      32'(ssg),        32'(exp_ssg(8'h10)));
      pulse_err_clr();
      check("ovf_cleared",   32'(overflow),   32'd0);

      // full FIFO, pop on the push cycle
      frame_q.push_back(8'h11);
      fork
         send_frame(8'h11, 1'b1);
         begin
            n = 0;
            while (rx_dv_n !== 1'b0 && n < 400) begin
               tick();
               n++;
            end
            if (n >= 400) begin
               vectors++;
               miscompares++;
               $display("FAIL push_pop_wait: got no rx_dv_n pulse within 400 cycles, expected one");
            end else begin
               exp_q.push_back(8'h00);
               rd_en = 1'b1;
               tick();
               rd_en = 1'b0;
            end
         end
      join
      check("pushpop_count",    32'(fifo_count), 32'd16);
      check("pushpop_overflow", 32'(overflow),   32'd0);
      for (int i = 1; i <= 15; i++) pop_expect(8'(i));
      pop_expect(8'h11);
      check("drain_count", 32'(fifo_count), 32'd0);
      check("drain_byte",  32'(rx_byte),    32'd0);

      // reset in the middle of DATA
      frame_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      check("pre_rst_count", 32'(fifo_count), 32'd1);
      rx_serial = 1'b0;
      wait_cycles(CPB);
      rx_serial = 1'b1;
      wait_cycles(8);
      rst_n = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(3 * CPB);
      check("midrst_count", 32'(fifo_count),       32'd0);
      check("midrst_valid", 32'(rx_valid),         32'd0);
      check("midrst_ssg",   32'(ssg),              32'(exp_ssg(8'h00)));
      check("midrst_state", 32'(dut.u_core.state), 32'(IDLE));
      frame_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      check("post_rst_count", 32'(fifo_count), 32'd1);
      check("post_rst_byte",  32'(rx_byte),    32'h81);
      pop_expect(8'h81);
      check("post_rst_empty", 32'(fifo_count), 32'd0);

`ifdef UART_PARITY_EN
      // wrong even-parity bit
      send_raw({5'b0, 1'b1, ~(^8'h3C), 8'h3C, 1'b0}, 11);
      check("badpar_frame_err", 32'(frame_err),  32'd1);
      check("badpar_count",     32'(fifo_count), 32'd0);
      pulse_err_clr();
      check("badpar_cleared",   32'(frame_err),  32'd0);
`endif

      wait_cycles(4);
      check("frames_outstanding", 32'(frame_q.size()), 32'd0);
      check("pops_outstanding",   32'(exp_q.size()),   32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
